// File: rtl/sysref_mon_pkg.sv
// Shared types and helpers for the SYSREF alignment monitor.
package sysref_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_ERROR   = 2'd3
    } state_e;

    // True when two periods differ by no more than tol cycles.
    function automatic logic period_match(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] tol);
        logic [31:0] diff;
        diff = (a >= b) ? (a - b) : (b - a);
        return diff <= tol;
    endfunction

endpackage

// File: rtl/sysref_edge_det.sv
// Two-flop rising-edge detector with a registered one-cycle strobe.
module sysref_edge_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic rise_o
);

    logic sysref_q;
    logic sysref_d;
    logic rise_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sysref_q <= 1'b0;
            sysref_d <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            sysref_q <= sig_i;
            sysref_d <= sysref_q;
            rise_q   <= sysref_q & ~sysref_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/sysref_align_monitor.sv
// Measures SYSREF edge spacing, declares lock after stable periods, and
// emits one SYSREF-aligned sync pulse per arm request while locked.
module sysref_align_monitor
    import sysref_mon_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int LOCK_COUNT = 4,
    parameter int TOL        = 0
) (
    input  logic             pl_clk,
    input  logic             pl_resetn,
    input  logic             sysref_in,
    input  logic             enable,
    input  logic             clear_err,
    input  logic             arm,
    output logic             sysref_edge,
    output logic             sync_pulse,
    output logic             sysref_locked,
    output logic             sysref_err,
    output logic [CNT_W-1:0] ref_period,
    output logic [CNT_W-1:0] last_period,
    output logic [1:0]       state_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]       LOCK_N  = 8'(LOCK_COUNT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ref_q, ref_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic [7:0]       match_q, match_d;
    logic             started_q, started_d;
    logic             arm_pend_q, arm_pend_d;
    logic             err_q, err_d;

    logic edge_raw;
    logic edge_s;
    logic is_match;
    logic sat;

    sysref_edge_det u_edge_det (
        .clk_i  (pl_clk),
        .rst_ni (pl_resetn),
        .sig_i  (sysref_in),
        .rise_o (edge_raw)
    );

    // Strobes are suppressed while disabled so IDLE presents all-zero outputs.
    assign edge_s   = edge_raw & (state_q != ST_IDLE);
    assign is_match = period_match(32'(cnt_q), 32'(ref_q), 32'(TOL));
    assign sat      = (cnt_q == CNT_MAX);

    always_ff @(posedge pl_clk or negedge pl_resetn) begin
        if (!pl_resetn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ref_q      <= '0;
            last_q     <= '0;
            match_q    <= '0;
            started_q  <= 1'b0;
            arm_pend_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ref_q      <= ref_d;
            last_q     <= last_d;
            match_q    <= match_d;
            started_q  <= started_d;
            arm_pend_q <= arm_pend_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ref_d      = ref_q;
        last_d     = last_q;
        match_d    = match_q;
        started_d  = started_q;
        err_d      = err_q;
        arm_pend_d = arm_pend_q;

        // The period is the count held during the strobe cycle.
        if (edge_s) begin
            cnt_d  = CNT_ONE;
            last_d = cnt_q;
        end else if (!sat) begin
            cnt_d = cnt_q + CNT_ONE;
        end

        unique case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                state_d = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
                if (edge_s) begin
                    if (!started_q) begin
                        started_d = 1'b1;
                    end else if (match_q == 8'd0 || !is_match) begin
                        ref_d   = cnt_q;
                        match_d = 8'd1;
                    end else begin
                        match_d = match_q + 8'd1;
                    end
                    if (started_q && match_d == LOCK_N) state_d = ST_LOCKED;
                end else if (started_q && sat) begin
                    started_d = 1'b0;
                    match_d   = '0;
                end
            end
            ST_LOCKED: begin
                if ((edge_s && !is_match) || (!edge_s && sat)) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                end
            end
            ST_ERROR: begin
                if (clear_err) begin
                    state_d   = ST_ACQUIRE;
                    err_d     = 1'b0;
                    match_d   = '0;
                    started_d = 1'b0;
                end
            end
        endcase

        if (!enable) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            ref_d     = '0;
            last_d    = '0;
            match_d   = '0;
            started_d = 1'b0;
            err_d     = 1'b0;
        end

        // A new arm outranks the clear from a firing pulse so it waits for the next edge.
        if (sync_pulse) arm_pend_d = 1'b0;
        if (arm && state_q != ST_IDLE) arm_pend_d = 1'b1;
        if ((state_q == ST_LOCKED && state_d != ST_LOCKED) || state_d == ST_IDLE)
            arm_pend_d = 1'b0;
    end

    always_comb begin
        sysref_edge   = edge_s;
        sync_pulse    = edge_s & arm_pend_q & (state_q == ST_LOCKED) & is_match;
        sysref_locked = (state_q == ST_LOCKED);
        sysref_err    = err_q;
        ref_period    = ref_q;
        last_period   = last_q;
        state_o       = state_q;
    end

endmodule

// File: tb/tb_sysref_align_monitor.sv
// Randomized scoreboard bench: two monitors (TOL=0 and TOL=1) share one SYSREF stream.
module tb_sysref_align_monitor;

    localparam int LC   = 4;
    localparam int MAXC = 255;

    logic       pl_clk = 1'b0;
    logic       pl_resetn = 1'b1;
    logic       sysref_in = 1'b0;
    logic       enable = 1'b0;
    logic       clear_err = 1'b0;
    logic       arm = 1'b0;
    logic       edge_a, sync_a, lock_a, err_a, edge_b, sync_b, lock_b, err_b;
    logic [7:0] ref_a, last_a, ref_b, last_b;
    logic [1:0] st_a, st_b;

    always #5 pl_clk = ~pl_clk;

    sysref_align_monitor #(.CNT_W(8), .LOCK_COUNT(LC), .TOL(0)) dut_a (
        .pl_clk(pl_clk), .pl_resetn(pl_resetn), .sysref_in(sysref_in), .enable(enable),
        .clear_err(clear_err), .arm(arm), .sysref_edge(edge_a), .sync_pulse(sync_a),
        .sysref_locked(lock_a), .sysref_err(err_a), .ref_period(ref_a),
        .last_period(last_a), .state_o(st_a));

    sysref_align_monitor #(.CNT_W(8), .LOCK_COUNT(LC), .TOL(1)) dut_b (
        .pl_clk(pl_clk), .pl_resetn(pl_resetn), .sysref_in(sysref_in), .enable(enable),
        .clear_err(clear_err), .arm(arm), .sysref_edge(edge_b), .sync_pulse(sync_b),
        .sysref_locked(lock_b), .sysref_err(err_b), .ref_period(ref_b),
        .last_period(last_b), .state_o(st_b));

    typedef struct {
        int st; bit err; int refp; int last; bit chk_last; bit sync; int cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t pend[2];
    bit   have[2];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_rise = 0;

    // Reference model: 0 idle, 1 acquire, 2 locked, 3 error.
    int m_st[2], m_ref[2], m_run[2];
    bit m_started[2], m_arm[2], m_err[2], m_fresh[2];

    always @(posedge pl_clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_idle();
        for (int j = 0; j < 2; j++) begin
            m_st[j] = 0; m_ref[j] = 0; m_run[j] = 0;
            m_started[j] = 0; m_arm[j] = 0; m_err[j] = 0;
        end
    endtask

    task automatic model_enable();
        for (int j = 0; j < 2; j++) begin
            m_st[j] = 1; m_run[j] = 0; m_started[j] = 0; m_fresh[j] = 1;
        end
    endtask

    task automatic model_edge(int j, int gap, int armidx, output exp_t e);
        int  pm, prev, diff;
        bit  m, left;
        pm   = (gap > MAXC) ? MAXC : gap;
        prev = m_st[j];
        if ((armidx == 0 || armidx == 1) && m_st[j] != 0) m_arm[j] = 1;
        e.sync     = 0;
        e.last     = pm;
        e.chk_last = !m_fresh[j];
        m_fresh[j] = 0;
        diff = (pm >= m_ref[j]) ? pm - m_ref[j] : m_ref[j] - pm;
        m    = (diff <= j);
        if (m_st[j] == 1) begin
            if (!m_started[j]) m_started[j] = 1;
            else begin
                if (m_run[j] == 0 || !m) begin m_ref[j] = pm; m_run[j] = 1; end
                else m_run[j]++;
                if (m_run[j] == LC) m_st[j] = 2;
            end
        end else if (m_st[j] == 2) begin
            if (!m) begin m_st[j] = 3; m_err[j] = 1; end
            else if (m_arm[j]) begin e.sync = 1; m_arm[j] = 0; end
        end
        left = (prev == 2 && m_st[j] != 2);
        if (left) m_arm[j] = 0;
        if ((armidx == 2 && !left) || armidx == 3) m_arm[j] = 1;
        e.st = m_st[j]; e.err = m_err[j]; e.refp = m_ref[j];
    endtask

    // One SYSREF period: high for h cycles; arm strobed at cycle armidx (-1 none).
    task automatic pulse(int p, int h, int armidx);
        exp_t e;
        int   gap;
        gap = cyc - last_rise;
        last_rise = cyc;
        model_edge(0, gap, armidx, e); e.cyc = cyc + 2; qa.push_back(e);
        model_edge(1, gap, armidx, e); e.cyc = cyc + 2; qb.push_back(e);
        for (int i = 0; i < p; i++) begin
            sysref_in = (i < h);
            arm = (i == armidx);
            @(negedge pl_clk);
        end
        sysref_in = 1'b0; arm = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            sysref_in = 1'b0; arm = 1'b0;
            @(negedge pl_clk);
        end
    endtask

    task automatic idle_clr();
        for (int j = 0; j < 2; j++)
            if (m_st[j] == 3) begin
                m_st[j] = 1; m_err[j] = 0; m_run[j] = 0; m_started[j] = 0;
            end
        clear_err = 1'b1;
        @(negedge pl_clk);
        clear_err = 1'b0;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_A_outs"}, {edge_a, sync_a, lock_a, err_a, st_a, ref_a, last_a}, 0);
        chk({tag, "_B_outs"}, {edge_b, sync_b, lock_b, err_b, st_b, ref_b, last_b}, 0);
    endtask

    task automatic chk_state(string tag, int sa, int sb);
        chk({tag, "_A_state"}, st_a, sa);
        chk({tag, "_B_state"}, st_b, sb);
    endtask

    task automatic mon(int j, logic edg, logic sy, logic lk, logic er,
                       logic [1:0] st, logic [7:0] rp, logic [7:0] lp);
        exp_t  e;
        string s;
        s = (j == 0) ? "A" : "B";
        if (have[j]) begin
            have[j] = 0;
            e = pend[j];
            chk({s, "_state"}, st, e.st);
            chk({s, "_err"}, er, e.err);
            chk({s, "_ref_period"}, rp, e.refp);
            chk({s, "_locked"}, lk, (e.st == 2));
            if (e.chk_last) chk({s, "_last_period"}, lp, e.last);
        end
        if (j == 0 && qa.size() > 0 && qa[0].cyc < cyc) begin
            e = qa.pop_front(); checks++; failures++;
            $display("FAIL A_missing_edge: got none expected strobe at cycle %0d", e.cyc);
        end
        if (j == 1 && qb.size() > 0 && qb[0].cyc < cyc) begin
            e = qb.pop_front(); checks++; failures++;
            $display("FAIL B_missing_edge: got none expected strobe at cycle %0d", e.cyc);
        end
        if (edg) begin
            if ((j == 0 && qa.size() == 0) || (j == 1 && qb.size() == 0)) begin
                checks++; failures++;
                $display("FAIL %s_unexpected_edge: got strobe at cycle %0d expected none", s, cyc);
            end else begin
                e = (j == 0) ? qa.pop_front() : qb.pop_front();
                chk({s, "_edge_cycle"}, cyc, e.cyc);
                chk({s, "_sync_pulse"}, sy, e.sync);
                pend[j] = e;
                have[j] = 1;
            end
        end else if (sy) begin
            checks++; failures++;
            $display("FAIL %s_sync_without_edge: got 1 expected 0 at cycle %0d", s, cyc);
        end
    endtask

    always @(posedge pl_clk) begin
        #1;
        mon(0, edge_a, sync_a, lock_a, err_a, st_a, ref_a, last_a);
        mon(1, edge_b, sync_b, lock_b, err_b, st_b, ref_b, last_b);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, p, dev, r, ai;
        model_idle();
        #1 pl_resetn = 1'b0;
        #3 chk_zero("reset");
        idle(3);
        pl_resetn = 1'b1;
        idle(2);
        enable = 1'b1;
        model_enable();
        idle(3);

        // Lock at period 8, then a 9-cycle period: A (TOL=0) errors, B (TOL=1) holds.
        repeat (6) pulse(8, 4, -1);
        chk_state("lock8", 2, 2);
        chk("lock8_A_ref", ref_a, 8);
        pulse(9, 4, -1);
        repeat (3) pulse(8, 4, -1);
        chk_state("stretch", 3, 2);
        chk("stretch_A_err", err_a, 1);
        idle_clr();
        repeat (6) pulse(8, 4, -1);
        chk_state("relock", 2, 2);

        // SYSREF stops: counter saturation is a timeout while locked.
        for (int j = 0; j < 2; j++)
            if (m_st[j] == 2) begin m_st[j] = 3; m_err[j] = 1; m_arm[j] = 0; end
        idle(300);
        chk_state("timeout", 3, 3);
        chk("timeout_A_err", err_a, 1);
        chk("timeout_B_err", err_b, 1);
        idle_clr();
        chk_state("cleared", 1, 1);

        // Reference reload in acquisition: 8,8 then four 10s.
        foreach (qa[i]) ;
        pulse(8, 4, -1); pulse(8, 4, -1);
        repeat (5) pulse(10, 3, -1);
        chk_state("reload10", 2, 2);
        chk("reload10_A_ref", ref_a, 10);

        // Disable while locked.
        enable = 1'b0;
        model_idle();
        idle(2);
        chk_zero("disable");
        enable = 1'b1;
        model_enable();
        idle(2);

        // Sync pulse at period 16.
        repeat (5) pulse(16, 8, -1);
        chk_state("lock16", 2, 2);
        pulse(16, 8, 1);
        pulse(16, 8, -1);
        pulse(16, 8, 2);
        pulse(16, 8, -1);
        pulse(16, 8, -1);

        // Randomized stream around a random base period.
        base = 6 + $urandom_range(0, 11);
        repeat (6) pulse(base, 1 + $urandom_range(0, base - 2), -1);
        for (int n = 0; n < 40; n++) begin
            dev = 0;
            if ($urandom_range(0, 5) == 0) dev = $urandom_range(0, 4) - 2;
            p = base + dev;
            if (p < 6) p = 6;
            r = $urandom_range(0, 4);
            ai = (r == 2) ? 1 : (r == 3) ? 2 : (r == 4) ? 3 : -1;
            pulse(p, 1 + $urandom_range(0, p - 2), ai);
            if ((m_st[0] == 3 || m_st[1] == 3) && $urandom_range(0, 1) == 1) idle_clr();
        end

        // Asynchronous reset in the middle of acquisition.
        enable = 1'b0;
        model_idle();
        idle(2);
        enable = 1'b1;
        model_enable();
        idle(2);
        pulse(8, 4, -1); pulse(8, 4, -1);
        idle(3);
        #2 pl_resetn = 1'b0;
        model_idle();
        #1 chk_zero("async_reset");
        @(negedge pl_clk);
        pl_resetn = 1'b1;
        model_enable();
        idle(2);
        repeat (5) pulse(8, 4, -1);
        chk_state("after_reset", 2, 2);

        idle(4);
        chk("A_queue_drained", qa.size(), 0);
        chk("B_queue_drained", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
